// File: rtl/plate_track_ctrl_if.sv
// plate_track_ctrl_if: bundle between the border adjustment stage, the
// tracking controller and the downstream segmentation/recognition stages.
//   per_frame_vsync, plate_exist_flag, plate_boarder_*  : upstream frame data
//   lock_*, lock_valid, frame_update, track_state       : tracked window out
// Modports:
//   master : upstream/testbench side (drives frame data, observes window)
//   slave  : plate_track_ctrl side
interface plate_track_ctrl_if;
    logic       per_frame_vsync;
    logic       plate_exist_flag;
    logic [9:0] plate_boarder_up;
    logic [9:0] plate_boarder_down;
    logic [9:0] plate_boarder_left;
    logic [9:0] plate_boarder_right;
    logic [9:0] lock_up;
    logic [9:0] lock_down;
    logic [9:0] lock_left;
    logic [9:0] lock_right;
    logic       lock_valid;
    logic       frame_update;
    logic [1:0] track_state;

    modport master (
        output per_frame_vsync, plate_exist_flag,
        output plate_boarder_up, plate_boarder_down, plate_boarder_left, plate_boarder_right,
        input  lock_up, lock_down, lock_left, lock_right,
        input  lock_valid, frame_update, track_state
    );

    modport slave (
        input  per_frame_vsync, plate_exist_flag,
        input  plate_boarder_up, plate_boarder_down, plate_boarder_left, plate_boarder_right,
        output lock_up, lock_down, lock_left, lock_right,
        output lock_valid, frame_update, track_state
    );
endinterface

// File: rtl/plate_track_ctrl.sv
// plate_track_ctrl: frame-level confirm/lock/coast tracker for the plate
// window. Samples the adjusted borders once per frame (vsync rising edge + 2
// cycles) and publishes a stable, qualified character window.
// Ports:
//   clk    : pixel clock
//   rst_n  : asynchronous active-low reset
//   bus    : plate_track_ctrl_if.slave (frame data in, tracked window out)
// Parameters:
//   CONFIRM_FRAMES (2..15) consecutive consistent hits needed to lock
//   MISS_FRAMES    (1..15) consecutive misses that drop a lock
//   MOVE_TOL       max per-edge |new - ref| for a hit to be consistent
// Build option:
//   PLATE_TRACK_SMOOTH_EN  when defined, LOCK/COAST updates average the old
//                          and new edge instead of copying the new edge.
module plate_track_ctrl #(
    parameter int unsigned CONFIRM_FRAMES = 3,
    parameter int unsigned MISS_FRAMES    = 2,
    parameter int unsigned MOVE_TOL       = 8
) (
    input logic               clk,
    input logic               rst_n,
    plate_track_ctrl_if.slave bus
);

    localparam logic [1:0] StSearch  = 2'd0;
    localparam logic [1:0] StConfirm = 2'd1;
    localparam logic [1:0] StLock    = 2'd2;
    localparam logic [1:0] StCoast   = 2'd3;

    localparam logic [4:0]  ConfN = 5'(CONFIRM_FRAMES);
    localparam logic [4:0]  MissN = 5'(MISS_FRAMES);
    localparam logic [10:0] Tol   = 11'(MOVE_TOL);

    // Edge order inside the packed arrays: 0=up, 1=down, 2=left, 3=right.
    logic [3:0][9:0] new_b;
    logic [3:0][9:0] ref_b;
    logic [3:0][9:0] upd_b;
    logic [3:0][9:0] cand_q, cand_d;
    logic [3:0][9:0] lock_q, lock_d;
    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [3:0]      miss_q, miss_d;
    logic            vsync_q;
    logic [1:0]      dly_q;
    logic            vsync_rise;
    logic            sample;
    logic            hit;
    logic            consistent;

    function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] ax;
        logic [10:0] bx;
        ax = {1'b0, a};
        bx = {1'b0, b};
        return (ax >= bx) ? (ax - bx) : (bx - ax);
    endfunction

    assign new_b = {bus.plate_boarder_right, bus.plate_boarder_left,
                    bus.plate_boarder_down, bus.plate_boarder_up};

    // The upstream stage refreshes its borders on the edge cycle itself, so
    // the decision point is pushed two cycles later to see settled values.
    assign vsync_rise = bus.per_frame_vsync & ~vsync_q;
    assign sample     = dly_q[1];
    assign hit        = bus.plate_exist_flag;

    always_comb begin
        ref_b      = (state_q == StConfirm) ? cand_q : lock_q;
        consistent = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (abs_diff(new_b[i], ref_b[i]) > Tol) begin
                consistent = 1'b0;
            end
`ifdef PLATE_TRACK_SMOOTH_EN
            upd_b[i] = 10'((11'(lock_q[i]) + 11'(new_b[i])) >> 1);
`else
            upd_b[i] = new_b[i];
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        lock_d  = lock_q;
        cnt_d   = cnt_q;
        miss_d  = miss_q;
        if (sample) begin
            case (state_q)
                StSearch: begin
                    if (hit) begin
                        cand_d  = new_b;
                        cnt_d   = 4'd1;
                        state_d = StConfirm;
                    end
                end
                StConfirm: begin
                    if (hit && consistent) begin
                        cand_d = new_b;
                        cnt_d  = cnt_q + 4'd1;
                        if (({1'b0, cnt_q} + 5'd1) == ConfN) begin
                            // First lock is a direct copy, never smoothed.
                            lock_d  = new_b;
                            miss_d  = 4'd0;
                            state_d = StLock;
                        end
                    end else if (hit) begin
                        cand_d = new_b;
                        cnt_d  = 4'd1;
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = StSearch;
                    end
                end
                StLock: begin
                    if (hit && consistent) begin
                        lock_d = upd_b;
                        miss_d = 4'd0;
                    end else if (MissN == 5'd1) begin
                        cnt_d   = 4'd0;
                        miss_d  = 4'd0;
                        state_d = StSearch;
                    end else begin
                        miss_d  = 4'd1;
                        state_d = StCoast;
                    end
                end
                default: begin // StCoast
                    if (hit && consistent) begin
                        lock_d  = upd_b;
                        miss_d  = 4'd0;
                        state_d = StLock;
                    end else if (({1'b0, miss_q} + 5'd1) == MissN) begin
                        cnt_d   = 4'd0;
                        miss_d  = 4'd0;
                        state_d = StSearch;
                    end else begin
                        miss_d = miss_q + 4'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            dly_q   <= 2'b00;
            state_q <= StSearch;
            cand_q  <= '0;
            lock_q  <= '0;
            cnt_q   <= 4'd0;
            miss_q  <= 4'd0;
        end else begin
            vsync_q <= bus.per_frame_vsync;
            dly_q   <= {dly_q[0], vsync_rise};
            state_q <= state_d;
            cand_q  <= cand_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_d;
            miss_q  <= miss_d;
        end
    end

    assign bus.lock_up      = lock_q[0];
    assign bus.lock_down    = lock_q[1];
    assign bus.lock_left    = lock_q[2];
    assign bus.lock_right   = lock_q[3];
    // LOCK and COAST both have bit 1 set; lock_q is written on the same edge.
    assign bus.lock_valid   = state_q[1];
    assign bus.frame_update = sample;
    assign bus.track_state  = state_q;

endmodule

// File: tb/tb_plate_track_ctrl.sv
// Directed testbench for plate_track_ctrl (default parameters 3/2/8).
// Expected values are hand-derived; coast recovery expectation follows
// PLATE_TRACK_SMOOTH_EN.
module tb_plate_track_ctrl;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   fu_cnt;

    plate_track_ctrl_if bus ();

    plate_track_ctrl #(
        .CONFIRM_FRAMES(3),
        .MISS_FRAMES   (2),
        .MOVE_TOL      (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Counts frame_update pulses over n cycles, sampling at falling edges.
    task automatic count_fu(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.frame_update) c++;
        end
    endtask

    // One frame: single-cycle vsync with the given frame data. Returns just
    // after the edge that registers the FSM decision.
    task automatic do_frame(input logic ex, input logic [9:0] u, input logic [9:0] d,
                            input logic [9:0] l, input logic [9:0] r);
        @(negedge clk);
        bus.plate_exist_flag    = ex;
        bus.plate_boarder_up    = u;
        bus.plate_boarder_down  = d;
        bus.plate_boarder_left  = l;
        bus.plate_boarder_right = r;
        bus.per_frame_vsync     = 1'b1;
        @(negedge clk);
        bus.per_frame_vsync = 1'b0;
        @(negedge clk);
        check("frame_update_pulse", int'(bus.frame_update), 1);
        @(negedge clk);
    endtask

    task automatic check_lock(input string tag, input int u, input int d, input int l,
                              input int r);
        check({tag, "_up"},    int'(bus.lock_up),    u);
        check({tag, "_down"},  int'(bus.lock_down),  d);
        check({tag, "_left"},  int'(bus.lock_left),  l);
        check({tag, "_right"}, int'(bus.lock_right), r);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.per_frame_vsync     = 1'b0;
        bus.plate_exist_flag    = 1'b0;
        bus.plate_boarder_up    = '0;
        bus.plate_boarder_down  = '0;
        bus.plate_boarder_left  = '0;
        bus.plate_boarder_right = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_state", int'(bus.track_state), 0);
        check("rst_valid", int'(bus.lock_valid), 0);
        check("rst_fu", int'(bus.frame_update), 0);
        check_lock("rst", 0, 0, 0, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Jitter reject: frame 2 moves left by 12
        do_frame(1'b1, 10'd40, 10'd70, 10'd100, 10'd190);
        check("jit_f1_state", int'(bus.track_state), 1);
        do_frame(1'b1, 10'd40, 10'd70, 10'd112, 10'd190);
        check("jit_f2_state", int'(bus.track_state), 1);
        do_frame(1'b1, 10'd40, 10'd70, 10'd112, 10'd190);
        check("jit_f3_state", int'(bus.track_state), 1);
        check("jit_f3_valid", int'(bus.lock_valid), 0);
        do_frame(1'b1, 10'd40, 10'd70, 10'd112, 10'd190);
        check("jit_f4_state", int'(bus.track_state), 2);
        check("jit_f4_left", int'(bus.lock_left), 112);

        // Drop back to SEARCH
        do_frame(1'b0, 10'd0, 10'd0, 10'd0, 10'd0);
        do_frame(1'b0, 10'd0, 10'd0, 10'd0, 10'd0);
        check("jit_drop_state", int'(bus.track_state), 0);

        // Acquire; frame 2 up differs by exactly MOVE_TOL and stays consistent
        do_frame(1'b1, 10'd40, 10'd70, 10'd100, 10'd190);
        check("acq_f1_state", int'(bus.track_state), 1);
        do_frame(1'b1, 10'd48, 10'd70, 10'd100, 10'd190);
        check("acq_f2_state", int'(bus.track_state), 1);
        check("acq_f2_valid", int'(bus.lock_valid), 0);
        do_frame(1'b1, 10'd40, 10'd70, 10'd100, 10'd190);
        check("acq_f3_state", int'(bus.track_state), 2);
        check("acq_f3_valid", int'(bus.lock_valid), 1);
        check_lock("acq", 40, 70, 100, 190);

        // Coast and drop
        do_frame(1'b0, 10'd0, 10'd0, 10'd0, 10'd0);
        check("coast_state", int'(bus.track_state), 3);
        check("coast_valid", int'(bus.lock_valid), 1);
        check_lock("coast", 40, 70, 100, 190);
        do_frame(1'b0, 10'd0, 10'd0, 10'd0, 10'd0);
        check("drop_state", int'(bus.track_state), 0);
        check("drop_valid", int'(bus.lock_valid), 0);
        check_lock("drop_hold", 40, 70, 100, 190);

        // Coast recovery
        repeat (3) do_frame(1'b1, 10'd40, 10'd70, 10'd100, 10'd190);
        check("rec_lock_state", int'(bus.track_state), 2);
        do_frame(1'b0, 10'd0, 10'd0, 10'd0, 10'd0);
        check("rec_coast_state", int'(bus.track_state), 3);
        do_frame(1'b1, 10'd44, 10'd74, 10'd104, 10'd194);
        check("rec_state", int'(bus.track_state), 2);
`ifdef PLATE_TRACK_SMOOTH_EN
        check_lock("rec", 42, 72, 102, 192);
`else
        check_lock("rec", 44, 74, 104, 194);
`endif

        // Inconsistent hit while locked counts as a miss
        do_frame(1'b1, 10'd200, 10'd74, 10'd104, 10'd194);
        check("lock_jump_state", int'(bus.track_state), 3);

        // Reset one cycle after a vsync edge, while a sample is in flight
        do_frame(1'b1, 10'd44, 10'd74, 10'd104, 10'd194);
        check("prerst_state", int'(bus.track_state), 2);
        @(negedge clk);
        bus.per_frame_vsync = 1'b1;
        @(negedge clk);
        bus.per_frame_vsync = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_state", int'(bus.track_state), 0);
        check("midrst_valid", int'(bus.lock_valid), 0);
        check("midrst_fu", int'(bus.frame_update), 0);
        check_lock("midrst", 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_fu(8, fu_cnt);
        check("postrst_fu_count", fu_cnt, 0);

        // Single-cycle vsync pulses: one frame_update each
        bus.plate_exist_flag = 1'b0;
        begin
            int total;
            total = 0;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                bus.per_frame_vsync = 1'b1;
                @(negedge clk);
                bus.per_frame_vsync = 1'b0;
                count_fu(5, fu_cnt);
                total += fu_cnt;
            end
            check("pulse_fu_count", total, 3);

            // Vsync held high for 1000 cycles
            @(negedge clk);
            bus.per_frame_vsync = 1'b1;
            count_fu(1000, fu_cnt);
            total = fu_cnt;
            bus.per_frame_vsync = 1'b0;
            count_fu(5, fu_cnt);
            total += fu_cnt;
            check("held_fu_count", total, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
